jt12_wr_queue: RTL and testbench
================================

// Module: jt12_wr_queue
// PURPOSE
//  Upstream register-write sequencer for jt12_top (YM2612/YM2203/YM2610 configs). Buffers
//  (part, reg, value) write requests from a host/test driver in a FIFO and replays each as the
//  chip bus protocol: busy poll, address write, data write. Drives jt12 din/addr/cs_n/wr_n and
//  samples jt12 dout, so hosts never see chip busy timing.
// PARAMETERS
//  AW       4    FIFO address width; depth = 2**AW entries
//  BUSY_TO  255  max cen-qualified poll cycles on busy before giving up (8-bit range)
// PORTS
//  clk        in   1  system clock, same clock as jt12_top
//  rst_n      in   1  reset, asynchronous, active-low
//  cen        in   1  clock enable shared with jt12_top; all FSM/bus activity advances on cen=1
//  req_valid  in   1  host write request
//  req_ready  out  1  FIFO not full; transfer when req_valid&req_ready (independent of cen)
//  req_part   in   1  register bank: 0 -> addr 0/1, 1 -> addr 2/3
//  req_reg    in   8  register number
//  req_val    in   8  register value
//  chip_dout  in   8  jt12 dout; bit 7 = busy
//  chip_addr  out  2  to jt12 addr
//  chip_din   out  8  to jt12 din
//  chip_cs_n  out  1  to jt12 cs_n
//  chip_wr_n  out  1  to jt12 wr_n
//  level      out  AW+1  FIFO occupancy 0..2**AW
//  idle       out  1  FIFO empty and FSM in IDLE
//  to_err     out  1  sticky: a busy poll timed out
//  err_clr    in   1  clears to_err (priority over a same-cycle set)
// BEHAVIOUR
//  Reset (rst_n=0, async): FIFO flushed, level=0, req_ready=1, idle=1, to_err=0, state=IDLE,
//   chip_cs_n=1, chip_wr_n=1, chip_addr=0, chip_din=0. Reset mid-transaction aborts it;
//   bus strobes deassert immediately, no partial write is resumed.
//  FIFO: push on req_valid&req_ready; pop only in IDLE on cen when not empty. Push and pop in
//   the same clk both take effect, level unchanged. Pointers wrap mod 2**AW. Push when full
//   impossible (req_ready=0). Entry = {part, reg, val} (17 b), popped into holding regs.
//  FSM (transitions only when cen=1; outputs registered, held between cen pulses):
//   IDLE  : if FIFO non-empty -> pop, POLL; poll counter=0.
//   POLL  : cs_n=0, wr_n=1, addr={part,0}. Next cen: sample chip_dout[7].
//           busy=0 -> ADDR. busy=1 -> count++; count==BUSY_TO -> set to_err, -> ADDR anyway.
//   ADDR  : cs_n=0, wr_n=0, addr={part,0}, din=reg, one cen cycle -> GAP1.
//   GAP1  : cs_n=1, wr_n=1, one cen cycle -> DATA.
//   DATA  : cs_n=0, wr_n=0, addr={part,1}, din=val, one cen cycle -> GAP2.
//   GAP2  : cs_n=1, wr_n=1 -> IDLE (next entry polls, covering post-data busy).
//  Strobe shape: each write is exactly one cen period low; cs_n/wr_n never low in IDLE/GAP.
//  Minimum throughput: 6 cen cycles/entry when never busy (IDLE,POLL,ADDR,GAP1,DATA,GAP2).
//  cen=0 for any length freezes the FSM and bus outputs; FIFO push still accepted.
//  idle is combinational: (level==0)&&(state==IDLE).
//  err_clr and timeout on same cycle: to_err ends 0.
// STRUCTURE
//  Package jt12_wr_pkg: state enum (IDLE,POLL,ADDR,GAP1,DATA,GAP2), entry struct
//   {part,reg,val}, ST_BUSY_BIT=7 constant.
//  Sub-module jt12_wr_fifo: synchronous FIFO, async active-low reset, params AW/DW,
//   push/pop/full/empty/level. FSM + bus drivers + timeout counter in top module.
//  Whole block ~200-260 RTL lines.
// TESTING (bench: jt12_top YM2612 config, cen=1 unless stated, chip_dout from DUT)
//  1 Single write part=0 reg=0x28 val=0xF0 -> bus shows addr0/din28 strobe, then addr1/dinF0
//    strobe, 6 cen total, idle=1 after; key-on visible in jt12 state.
//  2 Fill 16 entries back-to-back -> req_ready=0 at level=16; 17th held; entries replay in
//    order; level decrements by 1 per entry; simultaneous push/pop keeps level constant.
//  3 Forced chip_dout[7]=1 for 40 polls -> ADDR follows 1 cen after busy drops; to_err=0.
//    Forced busy stuck -> ADDR after 255 polls, to_err=1; err_clr -> to_err=0.
//  4 cen at 1/6 duty, 3 writes -> strobes each exactly one cen period long, outputs stable
//    between cen pulses, identical write sequence as cen=1 run.
//  5 rst_n low during DATA -> cs_n=wr_n=1 within same clk (async), level=0, idle=1; after
//    release new write part=1 reg=0xB4 val=0xC0 drives addr 2 then 3.

Source files
------------

// File: rtl/jt12_wr_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jt12_wr_pkg
// Brief    : Shared types for the jt12 register-write queue.
// Revision : 1.0
// ============================================================================
package jt12_wr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POLL = 3'd1,
        ST_ADDR = 3'd2,
        ST_GAP1 = 3'd3,
        ST_DATA = 3'd4,
        ST_GAP2 = 3'd5
    } state_t;

    typedef struct packed {
        logic       part;
        logic [7:0] regn;
        logic [7:0] val;
    } entry_t;

    localparam int ENTRY_W     = $bits(entry_t);
    localparam int ST_BUSY_BIT = 7;

endpackage
`default_nettype wire

// File: rtl/jt12_wr_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : jt12_wr_queue_if
// Brief    : Host request handshake plus jt12 chip bus for the write queue.
// Revision : 1.0
// ============================================================================
interface jt12_wr_queue_if;

    logic       req_valid;
    logic       req_ready;
    logic       req_part;
    logic [7:0] req_reg;
    logic [7:0] req_val;

    logic [7:0] chip_dout;
    logic [1:0] chip_addr;
    logic [7:0] chip_din;
    logic       chip_cs_n;
    logic       chip_wr_n;

    // master: host/chip side (bench); slave: the queue itself
    modport master (
        output req_valid, req_part, req_reg, req_val, chip_dout,
        input  req_ready, chip_addr, chip_din, chip_cs_n, chip_wr_n
    );

    modport slave (
        input  req_valid, req_part, req_reg, req_val, chip_dout,
        output req_ready, chip_addr, chip_din, chip_cs_n, chip_wr_n
    );

endinterface
`default_nettype wire

// File: rtl/jt12_wr_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : jt12_wr_fifo
// Brief    : Synchronous FIFO with occupancy count, async active-low reset.
// Revision : 1.0
// ============================================================================
module jt12_wr_fifo #(
    parameter int AW = 4,
    parameter int DW = 17
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          i_push,
    input  wire logic [DW-1:0] i_din,
    input  wire logic          i_pop,
    output logic      [DW-1:0] o_dout,
    output logic               o_full,
    output logic               o_empty,
    output logic      [AW:0]   o_level
);

    localparam logic [AW:0] c_depth = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] r_mem [2**AW];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop  && !o_empty;
    assign o_full  = (r_level == c_depth);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_dout  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/jt12_wr_queue.sv
`default_nettype none
// ============================================================================
// Module   : jt12_wr_queue
// Brief    : Buffers (part, reg, value) writes and replays them on the jt12 bus
//            as busy poll, address strobe, data strobe.
// Revision : 1.0
// ============================================================================
module jt12_wr_queue
    import jt12_wr_pkg::*;
#(
    parameter int AW      = 4,
    parameter int BUSY_TO = 255
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        cen,
    jt12_wr_queue_if.slave   bus,
    input  wire logic        err_clr,
    output logic      [AW:0] level,
    output logic             idle,
    output logic             to_err
);

    localparam logic [7:0] c_busy_to = 8'(BUSY_TO);

    state_t               r_state, w_state_nx;
    entry_t               r_ent, w_ent_nx, w_head;
    logic [7:0]           r_cnt, w_cnt_nx;
    logic                 r_cs_n, w_cs_n_nx;
    logic                 r_wr_n, w_wr_n_nx;
    logic [1:0]           r_addr, w_addr_nx;
    logic [7:0]           r_din, w_din_nx;
    logic                 r_to_err;
    logic                 w_to_set;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [ENTRY_W-1:0]   w_head_bits;
    logic                 w_unused_dout;

    jt12_wr_fifo #(
        .AW (AW),
        .DW (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (bus.req_valid),
        .i_din   ({bus.req_part, bus.req_reg, bus.req_val}),
        .i_pop   (w_pop),
        .o_dout  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign w_head        = entry_t'(w_head_bits);
    assign w_unused_dout = ^bus.chip_dout[6:0];

    assign bus.req_ready = !w_full;
    assign bus.chip_cs_n = r_cs_n;
    assign bus.chip_wr_n = r_wr_n;
    assign bus.chip_addr = r_addr;
    assign bus.chip_din  = r_din;
    assign idle          = (level == '0) && (r_state == ST_IDLE);
    assign to_err        = r_to_err;

    // Bus outputs are computed alongside the next state so they always
    // describe the state the FSM is in and hold while cen is low.
    always_comb begin
        w_state_nx = r_state;
        w_ent_nx   = r_ent;
        w_cnt_nx   = r_cnt;
        w_cs_n_nx  = r_cs_n;
        w_wr_n_nx  = r_wr_n;
        w_addr_nx  = r_addr;
        w_din_nx   = r_din;
        w_pop      = 1'b0;
        w_to_set   = 1'b0;
        if (cen) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_ent_nx   = w_head;
                        w_cnt_nx   = '0;
                        w_state_nx = ST_POLL;
                        w_cs_n_nx  = 1'b0;
                        w_wr_n_nx  = 1'b1;
                        w_addr_nx  = {w_head.part, 1'b0};
                    end
                end
                ST_POLL: begin
                    w_cnt_nx = r_cnt + 8'd1;
                    if (!bus.chip_dout[ST_BUSY_BIT] || (w_cnt_nx == c_busy_to)) begin
                        w_to_set   = bus.chip_dout[ST_BUSY_BIT];
                        w_state_nx = ST_ADDR;
                        w_cs_n_nx  = 1'b0;
                        w_wr_n_nx  = 1'b0;
                        w_addr_nx  = {r_ent.part, 1'b0};
                        w_din_nx   = r_ent.regn;
                    end
                end
                ST_ADDR: begin
                    w_state_nx = ST_GAP1;
                    w_cs_n_nx  = 1'b1;
                    w_wr_n_nx  = 1'b1;
                end
                ST_GAP1: begin
                    w_state_nx = ST_DATA;
                    w_cs_n_nx  = 1'b0;
                    w_wr_n_nx  = 1'b0;
                    w_addr_nx  = {r_ent.part, 1'b1};
                    w_din_nx   = r_ent.val;
                end
                ST_DATA: begin
                    w_state_nx = ST_GAP2;
                    w_cs_n_nx  = 1'b1;
                    w_wr_n_nx  = 1'b1;
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_cs_n_nx  = 1'b1;
                    w_wr_n_nx  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ent    <= '0;
            r_cnt    <= '0;
            r_cs_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            r_addr   <= '0;
            r_din    <= '0;
            r_to_err <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_ent   <= w_ent_nx;
            r_cnt   <= w_cnt_nx;
            r_cs_n  <= w_cs_n_nx;
            r_wr_n  <= w_wr_n_nx;
            r_addr  <= w_addr_nx;
            r_din   <= w_din_nx;
            if (err_clr) begin
                r_to_err <= 1'b0;
            end else if (w_to_set) begin
                r_to_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jt12_wr_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_jt12_wr_queue
// Brief    : Directed and randomized self-checking bench for jt12_wr_queue.
// Revision : 1.0
// ============================================================================
module tb_jt12_wr_queue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       err_clr = 1'b0;
    logic       busy = 1'b0;
    logic [4:0] level;
    logic       idle;
    logic       to_err;

    int checks = 0;
    int errors = 0;

    bit cen_run = 1'b0;
    int cen_period = 1;
    int cen_cnt = 0;

    // Expected chip writes in order: {addr[1:0], din[7:0]}
    logic [9:0] exp_q[$];

    jt12_wr_queue_if bus();

    jt12_wr_queue #(
        .AW      (4),
        .BUSY_TO (255)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen     (cen),
        .bus     (bus),
        .err_clr (err_clr),
        .level   (level),
        .idle    (idle),
        .to_err  (to_err)
    );

    assign bus.chip_dout = {busy, 7'h15};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!cen_run) begin
            cen = 1'b0;
            cen_cnt = 0;
        end else begin
            cen = (cen_cnt == 0);
            cen_cnt = (cen_cnt + 1) % cen_period;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic p, input logic [7:0] r, input logic [7:0] v);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_part  = p;
        bus.req_reg   = r;
        bus.req_val   = v;
        while (!bus.req_ready && n < 2000) begin
            tick(1);
            n++;
        end
        if (n >= 2000) chk("push_timeout", n, 0);
        tick(1);
        bus.req_valid = 1'b0;
        exp_q.push_back({p, 1'b0, r});
        exp_q.push_back({p, 1'b1, v});
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (!idle && n < limit) begin
            tick(1);
            n++;
        end
        chk("idle_wait", idle, 1);
    endtask

    // Bus monitor: strobe order/content, strobe length in clk, hold while cen=0
    logic       mon_prev_wr = 1'b1;
    int         mon_dur = 0;
    bit         mon_valid = 1'b0;
    logic       mon_cen;
    logic [11:0] mon_prev, mon_cur;
    logic [9:0] mon_exp;

    always @(posedge clk) begin
        mon_cen = cen;
        #1;
        if (!rst_n) begin
            mon_prev_wr = 1'b1;
            mon_dur = 0;
            mon_valid = 1'b0;
        end else begin
            mon_cur = {bus.chip_cs_n, bus.chip_wr_n, bus.chip_addr, bus.chip_din};
            if (mon_valid && !mon_cen) chk("hold_no_cen", mon_cur, mon_prev);
            if (!bus.chip_wr_n && mon_prev_wr) begin
                mon_dur = 1;
                chk("strobe_cs", bus.chip_cs_n, 0);
                chk("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    chk("write_addr_din", {bus.chip_addr, bus.chip_din}, mon_exp);
                end
            end else if (!bus.chip_wr_n) begin
                mon_dur++;
            end else if (!mon_prev_wr) begin
                chk("strobe_len", mon_dur, cen_period);
            end
            mon_prev_wr = bus.chip_wr_n;
            mon_prev = mon_cur;
            mon_valid = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rr, vv;
        logic       pp;
        bus.req_valid = 1'b0;
        bus.req_part  = 1'b0;
        bus.req_reg   = 8'h00;
        bus.req_val   = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", level, 0);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_idle", idle, 1);
        chk("rst_to_err", to_err, 0);
        chk("rst_cs_n", bus.chip_cs_n, 1);
        chk("rst_wr_n", bus.chip_wr_n, 1);
        chk("rst_addr", bus.chip_addr, 0);
        chk("rst_din", bus.chip_din, 0);
        @(negedge clk) rst_n = 1'b1;
        tick(1);
        cen_run = 1'b1;
        tick(1);

        // Single write: 6 cen from pop back to idle
        push(1'b0, 8'h28, 8'hF0);
        chk("t1_level_push", level, 1);
        tick(1);
        chk("t1_poll_cs", bus.chip_cs_n, 0);
        chk("t1_poll_wr", bus.chip_wr_n, 1);
        chk("t1_level_pop", level, 0);
        tick(1);
        chk("t1_addr_strobe", {bus.chip_cs_n, bus.chip_wr_n, bus.chip_addr, bus.chip_din}, {2'b00, 2'd0, 8'h28});
        tick(2);
        chk("t1_data_strobe", {bus.chip_cs_n, bus.chip_wr_n, bus.chip_addr, bus.chip_din}, {2'b00, 2'd1, 8'hF0});
        tick(1);
        chk("t1_gap2_cs", bus.chip_cs_n, 1);
        chk("t1_gap2_idle", idle, 0);
        tick(1);
        chk("t1_idle", idle, 1);

        // Fill with cen frozen, then drain in order
        cen_run = 1'b0;
        tick(2);
        for (int i = 0; i < 16; i++) begin
            push(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end
        chk("t2_full_level", level, 16);
        chk("t2_full_ready", bus.req_ready, 0);
        bus.req_valid = 1'b1;
        tick(3);
        chk("t2_held_level", level, 16);
        bus.req_valid = 1'b0;
        cen_run = 1'b1;
        tick(1);
        chk("t2_drain_0", level, 15);
        for (int k = 1; k <= 15; k++) begin
            tick(6);
            chk("t2_drain_k", level, 15 - k);
        end
        tick(4);
        chk("t2_last_gap2_idle", idle, 0);
        tick(1);
        chk("t2_last_idle", idle, 1);

        // Push coinciding with pop keeps level constant
        push(1'b1, 8'h30, 8'h71);
        push(1'b0, 8'hA4, 8'h22);
        chk("t2_pushpop_level", level, 1);
        tick(5);
        chk("t2_wait_level", level, 1);
        tick(1);
        chk("t2_second_pop", level, 0);
        wait_idle(50);

        // Busy for 40 polls, then released
        busy = 1'b1;
        push(1'b0, 8'hB0, 8'h32);
        tick(41);
        chk("t3_busy_wr", bus.chip_wr_n, 1);
        chk("t3_busy_cs", bus.chip_cs_n, 0);
        busy = 1'b0;
        tick(1);
        chk("t3_addr_after_busy", bus.chip_wr_n, 0);
        chk("t3_no_err", to_err, 0);
        wait_idle(50);

        // Stuck busy: timeout after 255 polls
        busy = 1'b1;
        push(1'b1, 8'h40, 8'h7F);
        tick(255);
        chk("t3_to_pre_wr", bus.chip_wr_n, 1);
        chk("t3_to_pre_err", to_err, 0);
        tick(1);
        chk("t3_to_wr", bus.chip_wr_n, 0);
        chk("t3_to_addr", bus.chip_addr, 2);
        chk("t3_to_err", to_err, 1);
        busy = 1'b0;
        wait_idle(50);
        chk("t3_err_sticky", to_err, 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t3_err_clr", to_err, 0);

        // Clear on the same cycle as a timeout wins
        busy = 1'b1;
        push(1'b0, 8'h41, 8'h05);
        tick(255);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t3_clr_vs_set", to_err, 0);
        chk("t3_clr_vs_set_wr", bus.chip_wr_n, 0);
        busy = 1'b0;
        wait_idle(50);
        chk("t3_clr_after", to_err, 0);

        // Sparse cen: strobes last one cen period, outputs hold between pulses
        cen_period = 6;
        for (int i = 0; i < 3; i++) begin
            pp = 1'($urandom_range(0, 1));
            rr = 8'($urandom);
            vv = 8'($urandom);
            push(pp, rr, vv);
        end
        wait_idle(300);
        chk("t4_queue_drained", exp_q.size(), 0);
        cen_period = 1;
        tick(12);

        // Reset during DATA aborts the write
        push(1'b0, 8'h50, 8'h11);
        push(1'b1, 8'h51, 8'h12);
        push(1'b0, 8'h52, 8'h13);
        chk("t5_level", level, 2);
        tick(2);
        chk("t5_in_data", {bus.chip_wr_n, bus.chip_addr}, {1'b0, 2'd1});
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_cs", bus.chip_cs_n, 1);
        chk("t5_rst_wr", bus.chip_wr_n, 1);
        chk("t5_rst_level", level, 0);
        chk("t5_rst_idle", idle, 1);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        tick(1);
        chk("t5_post_idle", idle, 1);
        push(1'b1, 8'hB4, 8'hC0);
        tick(1);
        chk("t5_poll_addr", bus.chip_addr, 2);
        tick(1);
        chk("t5_addr_strobe", {bus.chip_wr_n, bus.chip_addr, bus.chip_din}, {1'b0, 2'd2, 8'hB4});
        tick(2);
        chk("t5_data_strobe", {bus.chip_wr_n, bus.chip_addr, bus.chip_din}, {1'b0, 2'd3, 8'hC0});
        wait_idle(50);

        tick(4);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
